// File: rtl/apb_regfile_slave_if.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave_if
// APB bus bundle between an APB master (interconnect) and the register-file
// slave apb_regfile_slave.
//
// Signals:
//   paddr   [ADDR_WIDTH]   byte address, word index = paddr[ADDR_WIDTH-1:2]
//   psel                   slave select
//   penable                access phase
//   pwrite                 1 = write, 0 = read
//   pwdata  [DATA_WIDTH]   write data
//   pstrb   [DATA_WIDTH/8] byte lane strobes
//   pready                 transfer complete (slave -> master)
//   prdata  [DATA_WIDTH]   read data         (slave -> master)
//   pslverr                error response    (slave -> master)
// ---------------------------------------------------------------------------
interface apb_regfile_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
// Parametrised APB slave holding NUM_REGS registers of DATA_WIDTH bits with
// programmable wait states, byte strobes and an error response. Register
// contents and one-cycle write strobes are exported to core logic; slots
// marked in RO_MASK are read-only and return hardware status from hw_rdata.
//
// Ports:
//   pclk      in   APB clock
//   preset    in   asynchronous active-high reset
//   s_apb     slave modport of apb_regfile_slave_if (APB bus)
//   reg_q     out  flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse  out  one-cycle strobe, bit i after a committed write to reg i
//   hw_rdata  in   hardware values returned for read-only registers
//
// Configuration macro:
//   APB_REGFILE_STRB_EN  defined: pstrb selects the byte lanes written and
//                        pstrb==0 is a no-op write. Undefined: pstrb is
//                        ignored and every error-free write is full-word.
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
    parameter int                 ADDR_WIDTH  = 12,
    parameter int                 DATA_WIDTH  = 32,
    parameter int                 NUM_REGS    = 16,
    parameter int                 WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    apb_regfile_slave_if.slave             s_apb,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int NB    = DATA_WIDTH / 8;

    // ST_SETUP: a transfer completed last cycle; the bus is now either in a
    // back-to-back setup phase or going idle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic [IDX_W-1:0]      w_idx;
    logic [NUM_REGS-1:0]   w_sel;
    logic                  w_ro;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_err;
    logic [NB-1:0]         w_be;
    logic                  w_pready;
    logic                  w_commit;

    assign w_idx = s_apb.paddr[ADDR_WIDTH-1:2];

    // One-hot decode; an index beyond NUM_REGS leaves w_sel all-zero, which
    // doubles as the out-of-range indication.
    always_comb begin
        w_sel   = '0;
        w_ro    = 1'b0;
        w_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_sel[i] = 1'b1;
                w_ro     = RO_MASK[i];
                w_rdata  = RO_MASK[i] ? hw_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                                      : r_regs[i];
            end
        end
    end

    assign w_err = (s_apb.paddr[1:0] != 2'b00) | ~(|w_sel) | (s_apb.pwrite & w_ro);

`ifdef APB_REGFILE_STRB_EN
    assign w_be = s_apb.pstrb;
`else
    // pstrb stays on the bus but every lane is forced on.
    assign w_be = s_apb.pstrb | {NB{1'b1}};
`endif

    assign w_pready = (r_state == ST_ACCESS) && (r_cnt == 4'(WAIT_CYCLES));

    // Commit only while the master still holds the access phase, so a psel
    // drop in the completing cycle cannot write.
    assign w_commit = w_pready & s_apb.psel & s_apb.penable & s_apb.pwrite
                    & ~w_err & (|w_be);

    assign s_apb.pready  = w_pready;
    assign s_apb.pslverr = w_pready & w_err;
    assign s_apb.prdata  = (w_pready & ~w_err & ~s_apb.pwrite) ? w_rdata : '0;

    // ---- transfer FSM and wait counter ----
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (s_apb.psel && !s_apb.penable) begin
            // A setup phase restarts tracking from any state.
            r_state <= ST_ACCESS;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_ACCESS: begin
                    if (!s_apb.psel) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_pready) begin
                        r_state <= ST_SETUP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ---- register storage and write strobes ----
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_commit ? w_sel : '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_commit && w_sel[i] && w_be[b]) begin
                        r_regs[i][b*8 +: 8] <= s_apb.pwdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
        end
    end

    assign wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_apb_regfile_slave.sv
module tb_apb_regfile_slave;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0008;
    localparam int WAITS [2] = '{0, 3};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic          psel0, psel3, penable;

    logic [NR*DW-1:0] regq0, regq3, hw0, hw3;
    logic [NR-1:0]    wp0, wp3;

    apb_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    apb_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    assign bus0.paddr   = paddr;
    assign bus0.psel    = psel0;
    assign bus0.penable = penable & psel0;
    assign bus0.pwrite  = pwrite;
    assign bus0.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;
    assign bus3.paddr   = paddr;
    assign bus3.psel    = psel3;
    assign bus3.penable = penable & psel3;
    assign bus3.pwrite  = pwrite;
    assign bus3.pwdata  = pwdata;
    assign bus3.pstrb   = pstrb;

    apb_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                        .WAIT_CYCLES(0), .RO_MASK(RO)) u_dut0 (
        .pclk(clk), .preset(rst), .s_apb(bus0.slave),
        .reg_q(regq0), .wr_pulse(wp0), .hw_rdata(hw0));

    apb_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
                        .WAIT_CYCLES(3), .RO_MASK(RO)) u_dut3 (
        .pclk(clk), .preset(rst), .s_apb(bus3.slave),
        .reg_q(regq3), .wr_pulse(wp3), .hw_rdata(hw3));

    int n_checks = 0;
    int n_errors = 0;

    // Write-strobe monitor: each active bit seen at a negedge is one pulse-cycle.
    int          pulses [2] = '{0, 0};
    logic [15:0] last_pulse [2] = '{16'h0, 16'h0};
    always @(negedge clk) begin
        pulses[0] = pulses[0] + $countones(wp0);
        pulses[1] = pulses[1] + $countones(wp3);
        if (wp0 != 0) last_pulse[0] = wp0;
        if (wp3 != 0) last_pulse[1] = wp3;
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] mregs [2][NR];

    function automatic logic rdy(int k);
        return (k == 0) ? bus0.pready : bus3.pready;
    endfunction
    function automatic logic [DW-1:0] prd(int k);
        return (k == 0) ? bus0.prdata : bus3.prdata;
    endfunction
    function automatic logic perr(int k);
        return (k == 0) ? bus0.pslverr : bus3.pslverr;
    endfunction
    function automatic logic [NR*DW-1:0] regq(int k);
        return (k == 0) ? regq0 : regq3;
    endfunction

    function automatic bit exp_err(logic wr, logic [AW-1:0] a);
        int idx;
        idx = int'(a) / 4;
        if (a[1:0] != 2'b00) return 1'b1;
        if (idx >= NR) return 1'b1;
        if (wr && RO[idx]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] exp_read(int k, logic [AW-1:0] a);
        int idx;
        logic [NR*DW-1:0] hw;
        idx = int'(a) / 4;
        hw  = (k == 0) ? hw0 : hw3;
        if (exp_err(1'b0, a)) return '0;
        if (RO[idx]) return hw[idx*DW +: DW];
        return mregs[k][idx];
    endfunction

    task automatic model_write(input int k, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [3:0] s,
                               output int npulse);
        int idx;
        logic [3:0] be;
        npulse = 0;
        idx = int'(a) / 4;
`ifdef APB_REGFILE_STRB_EN
        be = s;
`else
        be = 4'hF;
`endif
        if (!exp_err(1'b1, a) && be != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mregs[k][idx][8*b +: 8] = d[8*b +: 8];
            npulse = 1;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) mregs[k][i] = '0;
    endtask

    // ---------------- bus driver ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic apb_xfer(input int k, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] s, input bit keep,
                            output logic [DW-1:0] rd, output logic err,
                            output int waits, output bit zero_before);
        bit done;
        paddr = a; pwrite = wr; pwdata = d; pstrb = s; penable = 1'b0;
        psel0 = (k == 0); psel3 = (k == 1);
        @(posedge clk); #1;
        penable = 1'b1;
        rd = '0; err = 1'b0; waits = 0; zero_before = 1'b1; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (rdy(k)) begin
                rd = prd(k); err = perr(k); done = 1'b1;
            end else begin
                if (prd(k) !== '0 || perr(k) !== 1'b0) zero_before = 1'b0;
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL xfer_timeout dut=%0d addr=%h: no pready within 40 cycles", k, a);
        end
        @(posedge clk); #1;
        if (!keep) begin
            psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        paddr = 12'h008; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        psel0 = 1'b1; psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({bus0.pready, bus3.pready} !== 2'b00) begin
                n_errors++; $display("FAIL reset_pready got=%b want=00", {bus0.pready, bus3.pready});
            end
            n_checks++;
            if ({bus0.pslverr, bus3.pslverr} !== 2'b00) begin
                n_errors++; $display("FAIL reset_pslverr got=%b want=00", {bus0.pslverr, bus3.pslverr});
            end
            n_checks++;
            if (bus0.prdata !== '0 || bus3.prdata !== '0) begin
                n_errors++; $display("FAIL reset_prdata got=%h/%h want=0", bus0.prdata, bus3.prdata);
            end
        end
        n_checks++;
        if (wp0 !== '0 || wp3 !== '0) begin
            n_errors++; $display("FAIL reset_wr_pulse got=%h/%h want=0", wp0, wp3);
        end
        n_checks++;
        if (regq0 !== '0 || regq3 !== '0) begin
            n_errors++; $display("FAIL reset_reg_q got nonzero want=0");
        end
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        @(negedge clk); rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd; logic err; int w; bit zb; int p0; logic [NR*DW-1:0] q;
        p0 = pulses[0];
        apb_xfer(0, 1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 1'b0, rd, err, w, zb);
        mregs[0][2] = 32'hDEADBEEF;
        n_checks++;
        if (w != 0) begin n_errors++; $display("FAIL wr_latency got=%0d want=0", w); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL wr_pslverr got=%b want=0", err); end
        q = regq0;
        n_checks++;
        if (q[2*DW +: DW] !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL wr_reg2 got=%h want=deadbeef", q[2*DW +: DW]);
        end
        n_checks++;
        if (pulses[0] - p0 != 1 || last_pulse[0] !== 16'h0004) begin
            n_errors++; $display("FAIL wr_pulse count=%0d vec=%h want 1 x 0004", pulses[0] - p0, last_pulse[0]);
        end
        apb_xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 1'b0, rd, err, w, zb);
        n_checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0 || w != 0) begin
            n_errors++; $display("FAIL rd_reg2 got=%h err=%b waits=%0d want=deadbeef 0 0", rd, err, w);
        end
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] rd, d; logic err; int w; bit zb; int np;
        d = $urandom;
        apb_xfer(1, 1'b1, 12'h004, d, 4'hF, 1'b0, rd, err, w, zb);
        model_write(1, 12'h004, d, 4'hF, np);
        n_checks++;
        if (w != 3) begin n_errors++; $display("FAIL wait_wr_latency got=%0d want=3", w); end
        apb_xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, 1'b0, rd, err, w, zb);
        n_checks++;
        if (w != 3) begin n_errors++; $display("FAIL wait_rd_latency got=%0d want=3", w); end
        n_checks++;
        if (!zb) begin n_errors++; $display("FAIL wait_prdata_early got=nonzero want=0 before pready"); end
        n_checks++;
        if (rd !== mregs[1][1]) begin n_errors++; $display("FAIL wait_rd_data got=%h want=%h", rd, mregs[1][1]); end
    endtask

    task automatic test_strobe();
        logic [DW-1:0] rd, want; logic err; int w; bit zb; int p0; logic [NR*DW-1:0] q;
        apb_xfer(0, 1'b1, 12'h004, 32'h11223344, 4'hF, 1'b0, rd, err, w, zb);
        apb_xfer(0, 1'b1, 12'h004, 32'hAABBCCDD, 4'b0101, 1'b0, rd, err, w, zb);
`ifdef APB_REGFILE_STRB_EN
        want = 32'h11BB33DD;
`else
        want = 32'hAABBCCDD;
`endif
        mregs[0][1] = want;
        q = regq0;
        n_checks++;
        if (q[1*DW +: DW] !== want) begin n_errors++; $display("FAIL strb_merge got=%h want=%h", q[1*DW +: DW], want); end
        p0 = pulses[0];
        apb_xfer(0, 1'b1, 12'h004, 32'h0BAD0BAD, 4'h0, 1'b0, rd, err, w, zb);
`ifdef APB_REGFILE_STRB_EN
        want = mregs[0][1];
`else
        want = 32'h0BAD0BAD;
`endif
        mregs[0][1] = want;
        q = regq0;
        n_checks++;
        if (q[1*DW +: DW] !== want || err !== 1'b0 || w != 0) begin
            n_errors++; $display("FAIL strb_zero got=%h err=%b waits=%0d want=%h 0 0", q[1*DW +: DW], err, w, want);
        end
        n_checks++;
`ifdef APB_REGFILE_STRB_EN
        if (pulses[0] - p0 != 0) begin n_errors++; $display("FAIL strb_zero_pulse got=%0d want=0", pulses[0] - p0); end
`else
        if (pulses[0] - p0 != 1) begin n_errors++; $display("FAIL strb_zero_pulse got=%0d want=1", pulses[0] - p0); end
`endif
    endtask

    task automatic test_errors();
        logic [AW-1:0] addrs [4] = '{12'h042, 12'h040, 12'h00C, 12'h042};
        logic          wrs   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] rd; logic err; int w; bit zb; int p0; logic [NR*DW-1:0] q_before, q;
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 4; t++) begin
                q_before = regq(k); p0 = pulses[k];
                apb_xfer(k, wrs[t], addrs[t], 32'hFFFF_FFFF, 4'hF, 1'b0, rd, err, w, zb);
                q = regq(k);
                n_checks++;
                if (err !== 1'b1 || w != WAITS[k]) begin
                    n_errors++; $display("FAIL err_resp dut=%0d addr=%h got err=%b waits=%0d want 1 %0d", k, addrs[t], err, w, WAITS[k]);
                end
                n_checks++;
                if (q !== q_before || pulses[k] != p0 || rd !== '0) begin
                    n_errors++; $display("FAIL err_side_effect dut=%0d addr=%h pulses=%0d rd=%h want no change, rd 0", k, addrs[t], pulses[k] - p0, rd);
                end
            end
        end
        apb_xfer(0, 1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, rd, err, w, zb);
        n_checks++;
        if (rd !== 32'h0000CAFE || err !== 1'b0) begin
            n_errors++; $display("FAIL ro_read got=%h err=%b want=0000cafe 0", rd, err);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [DW-1:0] rd; logic err; int w; bit zb; int np;
        apb_xfer(1, 1'b1, 12'h014, 32'h5555AAAA, 4'hF, 1'b0, rd, err, w, zb);
        paddr = 12'h018; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
        psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus3.pready !== 1'b0 || regq3 !== '0 || regq0 !== '0) begin
            n_errors++; $display("FAIL rst_mid_access pready=%b regs_zero=%b want 0 1", bus3.pready, (regq3 == '0 && regq0 == '0));
        end
        @(posedge clk); #1 psel3 = 1'b0; penable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus3.pready !== 1'b0) begin n_errors++; $display("FAIL rst_hold_pready got=%b want=0", bus3.pready); end
        rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        for (int i = 5; i <= 6; i++) begin
            apb_xfer(1, 1'b0, 12'(i * 4), 32'h0, 4'h0, 1'b0, rd, err, w, zb);
            n_checks++;
            if (rd !== '0 || err !== 1'b0) begin n_errors++; $display("FAIL rst_readback reg%0d got=%h want=0", i, rd); end
        end
        apb_xfer(1, 1'b1, 12'h018, 32'h600DF00D, 4'hF, 1'b0, rd, err, w, zb);
        model_write(1, 12'h018, 32'h600DF00D, 4'hF, np);
        apb_xfer(1, 1'b0, 12'h018, 32'h0, 4'h0, 1'b0, rd, err, w, zb);
        n_checks++;
        if (rd !== mregs[1][6] || w != 3) begin
            n_errors++; $display("FAIL rst_recover got=%h waits=%0d want=%h 3", rd, w, mregs[1][6]);
        end
    endtask

    task automatic test_psel_drop();
        logic [DW-1:0] rd; logic err; int w; bit zb; int np, p0; logic [NR*DW-1:0] q;
        apb_xfer(1, 1'b1, 12'h01C, 32'hC0FFEE00, 4'hF, 1'b0, rd, err, w, zb);
        model_write(1, 12'h01C, 32'hC0FFEE00, 4'hF, np);
        p0 = pulses[1];
        paddr = 12'h01C; pwrite = 1'b1; pwdata = 32'h0DEAD000; pstrb = 4'hF;
        psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel3 = 1'b0; penable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        q = regq3;
        n_checks++;
        if (q[7*DW +: DW] !== mregs[1][7] || pulses[1] != p0) begin
            n_errors++; $display("FAIL psel_drop got=%h pulses=%0d want=%h 0", q[7*DW +: DW], pulses[1] - p0, mregs[1][7]);
        end
        apb_xfer(1, 1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, rd, err, w, zb);
        n_checks++;
        if (rd !== mregs[1][7] || w != 3) begin
            n_errors++; $display("FAIL psel_drop_next got=%h waits=%0d want=%h 3", rd, w, mregs[1][7]);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rd, d; logic err; int w; bit zb; int np, p0;
        d = $urandom;
        p0 = pulses[0];
        apb_xfer(0, 1'b1, 12'h000, d, 4'hF, 1'b1, rd, err, w, zb);
        model_write(0, 12'h000, d, 4'hF, np);
        apb_xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, rd, err, w, zb);
        n_checks++;
        if (rd !== mregs[0][0] || w != 0 || err !== 1'b0) begin
            n_errors++; $display("FAIL b2b_read got=%h waits=%0d err=%b want=%h 0 0", rd, w, err, mregs[0][0]);
        end
        n_checks++;
        if (pulses[0] - p0 != 1) begin n_errors++; $display("FAIL b2b_pulses got=%0d want=1", pulses[0] - p0); end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, d, e_rd; logic err, wr, e_err; int w, k, idx, np, p0; bit zb;
        logic [AW-1:0] a; logic [3:0] s; logic [NR*DW-1:0] q;
        for (int n = 0; n < 80; n++) begin
            k   = $urandom_range(0, 1);
            idx = $urandom_range(0, 17);
            a   = AW'(idx * 4);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            wr  = 1'($urandom_range(0, 1));
            d   = $urandom;
            s   = 4'($urandom);
            e_err = exp_err(wr, a);
            e_rd  = exp_read(k, a);
            p0 = pulses[k];
            apb_xfer(k, wr, a, d, s, ($urandom_range(0, 1) == 1), rd, err, w, zb);
            np = 0;
            if (wr) model_write(k, a, d, s, np);
            n_checks++;
            if (err !== e_err || w != WAITS[k]) begin
                n_errors++; $display("FAIL rand_resp n=%0d dut=%0d addr=%h wr=%b got err=%b waits=%0d want %b %0d", n, k, a, wr, err, w, e_err, WAITS[k]);
            end
            if (!wr) begin
                n_checks++;
                if (rd !== e_rd) begin n_errors++; $display("FAIL rand_rdata n=%0d dut=%0d addr=%h got=%h want=%h", n, k, a, rd, e_rd); end
            end
            // back-to-back may leave the pulse cycle ahead; settle one cycle
            @(negedge clk); #1;
            n_checks++;
            if (pulses[k] - p0 != np) begin n_errors++; $display("FAIL rand_pulse n=%0d dut=%0d got=%0d want=%0d", n, k, pulses[k] - p0, np); end
            q = regq(k);
            for (int i = 0; i < NR; i++) begin
                if (!RO[i]) begin
                    n_checks++;
                    if (q[i*DW +: DW] !== mregs[k][i]) begin
                        n_errors++; $display("FAIL rand_reg n=%0d dut=%0d reg%0d got=%h want=%h", n, k, i, q[i*DW +: DW], mregs[k][i]);
                    end
                end
            end
            psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        for (int i = 0; i < NR; i++) begin
            hw0[i*DW +: DW] = $urandom;
            hw3[i*DW +: DW] = $urandom;
        end
        hw0[3*DW +: DW] = 32'h0000CAFE;
        test_reset();
        test_write_read();
        test_wait_states();
        test_strobe();
        test_errors();
        test_reset_mid_access();
        test_psel_drop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
